// File: rtl/display_pkg.sv
// display_pkg: frame-buffer geometry, pixel_writer FSM states and the FIFO entry type.
// The display size comes from the DISPLAY_WIDTH/DISPLAY_HEIGHT macros (types.sv).
// Fallback defaults apply when those macros are absent, so the slice also builds on its own.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif

package display_pkg;

  localparam int PW_WIDTH     = `DISPLAY_WIDTH;
  localparam int PW_HEIGHT    = `DISPLAY_HEIGHT;
  localparam int PW_H_BITS    = $clog2(PW_WIDTH);
  localparam int PW_V_BITS    = $clog2(PW_HEIGHT);
  localparam int PW_ADDR_BITS = PW_H_BITS + PW_V_BITS;

  // RUN accepts pixels; the other states walk the finished frame to a buffer swap.
  typedef enum logic [1:0] {
    RUN         = 2'd0,
    DRAIN       = 2'd1,
    WAIT_VBLANK = 2'd2,
    SWAP        = 2'd3
  } pw_state_t;

  // One pending frame-buffer write.
  typedef struct packed {
    logic [PW_ADDR_BITS-1:0] addr;
    logic [3:0]              color;
  } pixel_write_t;

endpackage

// File: rtl/pixel_writer_if.sv
// pixel_writer_if: pixel input stream, frame and vblank control, and the frame-buffer write port.
// The slave modport is the pixel_writer view. The master modport is the surrounding-system view
// (ray_marcher, VGA timing and bram_manager).
interface pixel_writer_if #(
  parameter int H_BITS    = 9,
  parameter int V_BITS    = 8,
  parameter int ADDR_BITS = H_BITS + V_BITS
);
  logic [H_BITS-1:0]    hcount_in;
  logic [V_BITS-1:0]    vcount_in;
  logic [3:0]           color_in;
  logic                 valid_in;
  logic                 new_frame_in;
  logic                 ready_out;
  logic                 vblank_in;
  logic                 write_ready_in;
  logic                 write_enable_out;
  logic [ADDR_BITS-1:0] write_addr_out;
  logic [3:0]           write_data_out;
  logic                 swap_buffers_out;

  modport slave (
    input  hcount_in, vcount_in, color_in, valid_in, new_frame_in,
    input  vblank_in, write_ready_in,
    output ready_out, write_enable_out, write_addr_out, write_data_out, swap_buffers_out
  );

  modport master (
    output hcount_in, vcount_in, color_in, valid_in, new_frame_in,
    output vblank_in, write_ready_in,
    input  ready_out, write_enable_out, write_addr_out, write_data_out, swap_buffers_out
  );
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of pixel_write_t. DEPTH must be a power of two.
// The head is visible on head the cycle after a push into an empty FIFO.
// A push while full is dropped and a pop while empty is ignored; the producer avoids both.
module pixel_fifo
  import display_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push,
  input  pixel_write_t           push_dat,
  input  logic                   pop,
  output pixel_write_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  pixel_write_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset: the empty flag masks stale contents.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; the pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: linearises marched pixels, queues them for the frame-buffer write port, and
// swaps buffers only after the frame has drained and the display is in vblank.
// Optional macro PIXEL_WRITER_STATS_EN adds drop_count_out, a saturating count of dropped pixels.
module pixel_writer
  import display_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int FIFO_DEPTH     = 8,
  parameter int H_BITS         = $clog2(DISPLAY_WIDTH),
  parameter int V_BITS         = $clog2(DISPLAY_HEIGHT),
  parameter int ADDR_BITS      = H_BITS + V_BITS
) (
  input  logic          clk_in,
  input  logic          rst_in,
  pixel_writer_if.slave bus
`ifdef PIXEL_WRITER_STATS_EN
  ,
  output logic [15:0]   drop_count_out
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [H_BITS:0] H_LIM = (H_BITS+1)'(DISPLAY_WIDTH);
  localparam logic [V_BITS:0] V_LIM = (V_BITS+1)'(DISPLAY_HEIGHT);

  pw_state_t            state;
  pw_state_t            state_nxt;
  logic                 accept;
  logic                 in_range;
  logic [ADDR_BITS-1:0] lin_addr;
  logic                 s1_valid;
  pixel_write_t         s1_dat;
  pixel_write_t         head;
  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  logic                 empty;
  logic                 full;
  logic                 pop;

  assign in_range  = ({1'b0, bus.hcount_in} < H_LIM) && ({1'b0, bus.vcount_in} < V_LIM);
  assign lin_addr  = ADDR_BITS'(bus.vcount_in) * ADDR_BITS'(DISPLAY_WIDTH)
                   + ADDR_BITS'(bus.hcount_in);

  // The pixel in S1 is counted, so the FIFO still has a slot for it when it lands.
  assign occupancy     = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign bus.ready_out = !rst_in && (state == RUN) && (occupancy <= (CW+1)'(FIFO_DEPTH - 1));
  assign accept        = bus.valid_in && bus.ready_out;

  // S1: register the linear address. Out-of-range pixels are accepted but not forwarded.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_dat   <= '0;
    end else begin
      s1_valid <= accept && in_range;
      if (accept) s1_dat <= '{addr: PW_ADDR_BITS'(lin_addr), color: bus.color_in};
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (s1_valid),
    .push_dat (s1_dat),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  // The head is held until bram_manager takes it; zeros are shown while the FIFO is empty.
  assign pop                  = !empty && bus.write_ready_in;
  assign bus.write_enable_out = !empty;
  assign bus.write_addr_out   = empty ? '0 : ADDR_BITS'(head.addr);
  assign bus.write_data_out   = empty ? 4'h0 : head.color;

  // Frame sequencing state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state and swap pulse. new_frame_in only matters in RUN.
  always_comb begin
    state_nxt            = state;
    bus.swap_buffers_out = 1'b0;
    case (state)
      RUN:         if (bus.new_frame_in) state_nxt = DRAIN;
      DRAIN:       if (!s1_valid && empty) state_nxt = WAIT_VBLANK;
      WAIT_VBLANK: if (bus.vblank_in) state_nxt = SWAP;
      SWAP: begin
        bus.swap_buffers_out = 1'b1;
        state_nxt            = RUN;
      end
      default:     state_nxt = RUN;
    endcase
  end

`ifdef PIXEL_WRITER_STATS_EN
  logic drop_evt;
  assign drop_evt = bus.valid_in && (!bus.ready_out || !in_range);

  // Saturating drop counter: refused cycles plus accepted-but-discarded pixels.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                drop_count_out <= 16'h0000;
    else if (drop_evt && drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'h0001;
  end
`endif

  logic unused_full;
  assign unused_full = full;
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed tests of pixel_writer at 320x240 with an 8-entry FIFO.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// With PIXEL_WRITER_STATS_EN defined the drop counter is checked as well.
module tb_pixel_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  pixel_writer_if #(.H_BITS(9), .V_BITS(8), .ADDR_BITS(17)) bus ();

`ifdef PIXEL_WRITER_STATS_EN
  logic [15:0] drop_count;
`endif

  pixel_writer #(.DISPLAY_WIDTH(320), .DISPLAY_HEIGHT(240), .FIFO_DEPTH(8)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
`ifdef PIXEL_WRITER_STATS_EN
    ,
    .drop_count_out (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in     = 1'b0;
    bus.new_frame_in = 1'b0;
    bus.hcount_in    = '0;
    bus.vcount_in    = '0;
    bus.color_in     = '0;
  endtask

  task automatic drive_pixel(input int h, input int v, input int c);
    bus.valid_in  = 1'b1;
    bus.hcount_in = 9'(h);
    bus.vcount_in = 8'(v);
    bus.color_in  = 4'(c);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.vblank_in      = 1'b0;
    bus.write_ready_in = 1'b1;
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.ready_out !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready_out); else passed++;
    checks++; if (bus.write_enable_out !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.write_enable_out); else passed++;
    checks++; if (bus.write_addr_out !== 17'd0) $display("FAIL reset_addr: got %0d want 0", bus.write_addr_out); else passed++;
    checks++; if (bus.write_data_out !== 4'h0) $display("FAIL reset_data: got %h want 0", bus.write_data_out); else passed++;
    checks++; if (bus.swap_buffers_out !== 1'b0) $display("FAIL reset_swap: got %b want 0", bus.swap_buffers_out); else passed++;
    rst = 1'b0;
    step();
    checks++; if (bus.ready_out !== 1'b1) $display("FAIL release_ready: got %b want 1", bus.ready_out); else passed++;
  endtask

  // (5,2) -> 2*320+5 = 645, visible two cycles after the accept for exactly one cycle.
  task automatic test_latency();
    bus.write_ready_in = 1'b1;
    drive_pixel(5, 2, 'hA);
    checks++; if (bus.ready_out !== 1'b1) $display("FAIL lat_ready: got %b want 1", bus.ready_out); else passed++;
    step();
    idle_inputs();
    checks++; if (bus.write_enable_out !== 1'b0) $display("FAIL lat_n1_we: got %b want 0", bus.write_enable_out); else passed++;
    step();
    checks++; if (bus.write_enable_out !== 1'b1) $display("FAIL lat_n2_we: got %b want 1", bus.write_enable_out); else passed++;
    checks++; if (bus.write_addr_out !== 17'd645) $display("FAIL lat_addr: got %0d want 645", bus.write_addr_out); else passed++;
    checks++; if (bus.write_data_out !== 4'hA) $display("FAIL lat_data: got %h want A", bus.write_data_out); else passed++;
    step();
    checks++; if (bus.write_enable_out !== 1'b0) $display("FAIL lat_n3_we: got %b want 0", bus.write_enable_out); else passed++;
  endtask

  // Five consecutive pixels on row 7 come out on five consecutive cycles.
  task automatic test_back_to_back();
    int refused = 0;
    int bad = 0;
    bus.write_ready_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        drive_pixel(20 + i, 7, i + 3);
        if (bus.ready_out !== 1'b1) refused++;
      end else begin
        idle_inputs();
      end
      if (i >= 2) begin
        if (bus.write_enable_out !== 1'b1 || bus.write_addr_out !== 17'(7*320 + 20 + i - 2)
            || bus.write_data_out !== 4'(i + 1)) begin
          bad++;
          $display("FAIL b2b_write%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   i - 2, bus.write_enable_out, bus.write_addr_out, bus.write_data_out,
                   7*320 + 20 + i - 2, 4'(i + 1));
        end
      end
      step();
    end
    checks++; if (refused !== 0) $display("FAIL b2b_ready: got %0d refused want 0", refused); else passed++;
    checks++; if (bad == 0) passed++;
  endtask

  // With the write port stalled, ready falls with 7 pixels in the FIFO and one in S1.
  task automatic test_backpressure();
    int accepted = 0;
    int unstable = 0;
    bus.write_ready_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_pixel(i, 1, i + 1);
      if (bus.ready_out === 1'b1) accepted++;
      step();
    end
    idle_inputs();
    checks++; if (accepted !== 8) $display("FAIL bp_accepted: got %0d want 8", accepted); else passed++;
    checks++; if (bus.ready_out !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", bus.ready_out); else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.write_enable_out !== 1'b1 || bus.write_addr_out !== 17'd320 || bus.write_data_out !== 4'h1)
        unstable++;
    end
    checks++; if (unstable !== 0) $display("FAIL bp_head_stable: got %0d unstable cycles want 0", unstable); else passed++;
    bus.write_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.write_enable_out !== 1'b1 || bus.write_addr_out !== 17'(320 + k) || bus.write_data_out !== 4'(k + 1))
        $display("FAIL bp_drain%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 k, bus.write_enable_out, bus.write_addr_out, bus.write_data_out, 320 + k, 4'(k + 1));
      else passed++;
      step();
    end
    checks++; if (bus.write_enable_out !== 1'b0) $display("FAIL bp_empty: got %b want 0", bus.write_enable_out); else passed++;
    checks++; if (bus.ready_out !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", bus.ready_out); else passed++;
  endtask

  task automatic test_out_of_range();
    int writes = 0;
    bus.write_ready_in = 1'b1;
    drive_pixel(320, 0, 'hF);
    step();
    drive_pixel(0, 240, 'hE);
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      if (bus.write_enable_out === 1'b1) writes++;
      step();
    end
    checks++; if (writes !== 0) $display("FAIL oor_writes: got %0d want 0", writes); else passed++;
`ifdef PIXEL_WRITER_STATS_EN
    // 4 refused cycles in the back-pressure test plus these 2 discarded pixels.
    checks++; if (drop_count !== 16'd6) $display("FAIL oor_drop_count: got %0d want 6", drop_count); else passed++;
`endif
  endtask

  task automatic test_frame_swap();
    int writes = 0;
    int swaps = 0;
    int last_addr = -1;
    int ready_bad = 0;
    logic prev_swap = 1'b0;
    bus.write_ready_in = 1'b0;
    bus.vblank_in      = 1'b0;
    drive_pixel(10, 3, 1);
    step();
    drive_pixel(11, 3, 2);
    step();
    drive_pixel(12, 3, 3);
    bus.new_frame_in = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.ready_out !== 1'b0) $display("FAIL fs_ready_drain: got %b want 0", bus.ready_out); else passed++;
    bus.write_ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.write_enable_out === 1'b1) begin
        writes++;
        last_addr = int'(bus.write_addr_out);
      end
      if (bus.swap_buffers_out === 1'b1) swaps++;
      step();
    end
    checks++; if (writes !== 3) $display("FAIL fs_writes: got %0d want 3", writes); else passed++;
    checks++; if (last_addr !== 972) $display("FAIL fs_last_addr: got %0d want 972", last_addr); else passed++;
    checks++; if (swaps !== 0) $display("FAIL fs_no_swap: got %0d want 0", swaps); else passed++;
    checks++; if (bus.ready_out !== 1'b0) $display("FAIL fs_ready_wait: got %b want 0", bus.ready_out); else passed++;
    bus.vblank_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (prev_swap && bus.ready_out !== 1'b1) ready_bad++;
      prev_swap = bus.swap_buffers_out;
      if (bus.swap_buffers_out === 1'b1) swaps++;
      step();
    end
    bus.vblank_in = 1'b0;
    checks++; if (swaps !== 1) $display("FAIL fs_swap_count: got %0d want 1", swaps); else passed++;
    checks++; if (ready_bad !== 0) $display("FAIL fs_ready_after_swap: got %0d bad want 0", ready_bad); else passed++;
  endtask

  // Repeated new_frame pulses during DRAIN still give one swap; vblank is already high.
  task automatic test_new_frame_ignored();
    int writes = 0;
    int swaps = 0;
    bus.write_ready_in = 1'b0;
    bus.vblank_in      = 1'b1;
    drive_pixel(0, 9, 5);
    step();
    drive_pixel(1, 9, 6);
    bus.new_frame_in = 1'b1;
    step();
    idle_inputs();
    bus.new_frame_in = 1'b1;
    step();
    step();
    bus.new_frame_in   = 1'b0;
    bus.write_ready_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) bus.new_frame_in = 1'b1;
      else        bus.new_frame_in = 1'b0;
      if (bus.write_enable_out === 1'b1) writes++;
      if (bus.swap_buffers_out === 1'b1) swaps++;
      if (bus.swap_buffers_out === 1'b1 || bus.ready_out === 1'b1) bus.new_frame_in = 1'b0;
      step();
    end
    bus.vblank_in = 1'b0;
    checks++; if (writes !== 2) $display("FAIL nf_writes: got %0d want 2", writes); else passed++;
    checks++; if (swaps !== 1) $display("FAIL nf_swap_count: got %0d want 1", swaps); else passed++;
    checks++; if (bus.ready_out !== 1'b1) $display("FAIL nf_ready: got %b want 1", bus.ready_out); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int writes = 0;
    int swaps = 0;
    bus.write_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pixel(30 + i, 4, 9);
      step();
    end
    idle_inputs();
    bus.new_frame_in = 1'b1;
    step();
    bus.new_frame_in = 1'b0;
    checks++; if (bus.write_enable_out !== 1'b1) $display("FAIL rm_we_before: got %b want 1", bus.write_enable_out); else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.write_enable_out !== 1'b0 || bus.write_addr_out !== 17'd0 || bus.write_data_out !== 4'h0
        || bus.ready_out !== 1'b0 || bus.swap_buffers_out !== 1'b0)
      $display("FAIL rm_async_zero: got we=%b addr=%0d data=%h ready=%b swap=%b want all 0",
               bus.write_enable_out, bus.write_addr_out, bus.write_data_out, bus.ready_out,
               bus.swap_buffers_out);
    else passed++;
    step();
    rst = 1'b0;
    bus.write_ready_in = 1'b1;
    bus.vblank_in      = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.write_enable_out === 1'b1) writes++;
      if (bus.swap_buffers_out === 1'b1) swaps++;
      step();
    end
    checks++; if (writes !== 0) $display("FAIL rm_writes: got %0d want 0", writes); else passed++;
    checks++; if (swaps !== 0) $display("FAIL rm_swaps: got %0d want 0", swaps); else passed++;
    checks++; if (bus.ready_out !== 1'b1) $display("FAIL rm_ready: got %b want 1", bus.ready_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_frame_swap();
    test_new_frame_ignored();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
